// File: rtl/up_counter_if.sv
// up_counter_if: control inputs and count/status outputs of up_counter
interface up_counter_if #(parameter int WIDTH = 4);
  logic en, clr, load, ovf_clr;
  logic [WIDTH-1:0] din, limit, q;
  logic tc, wrap, ovf;
  modport master(output en, clr, load, ovf_clr, din, limit, input q, tc, wrap, ovf);
  modport slave(input en, clr, load, ovf_clr, din, limit, output q, tc, wrap, ovf);
endinterface

// File: rtl/up_counter.sv
// up_counter: synchronous up counter wrapping at a live limit, with wrap pulse and sticky overflow
module up_counter #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  up_counter_if.slave bus
);
  logic [WIDTH-1:0] q, q_nxt;
  logic wrap, wrap_nxt, ovf, ovf_nxt;
  always_comb begin
    // all-ones also wraps so a count parked above limit never rolls over silently
    wrap_nxt = !bus.clr && !bus.load && bus.en && (q == bus.limit || q == '1);
    q_nxt = bus.clr ? '0 : bus.load ? bus.din : wrap_nxt ? '0 : bus.en ? q + WIDTH'(1) : q;
    ovf_nxt = bus.clr ? 1'b0 : wrap_nxt ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      wrap <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q <= q_nxt;
      wrap <= wrap_nxt;
      ovf <= ovf_nxt;
    end
  assign bus.q = q;
  assign bus.tc = q == bus.limit;
  assign bus.wrap = wrap;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed and random checks of up_counter against a behavioural model
module tb_up_counter;
  localparam int W = 4;
  localparam int MAX = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  up_counter_if #(.WIDTH(W)) bus();
  up_counter #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int mq = 0;
  bit mwrap = 1'b0;
  bit movf = 1'b0;
  logic [W+2:0] dutv;
  assign dutv = {bus.q, bus.tc, bus.wrap, bus.ovf};
  function automatic logic [W+2:0] expv();
    return {W'(mq), mq == int'(bus.limit), mwrap, movf};
  endfunction
  task automatic idle();
    bus.en = 0; bus.clr = 0; bus.load = 0; bus.ovf_clr = 0; bus.din = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (bus.clr) begin
      mq = 0; movf = 0; mwrap = 0;
    end else begin
      mwrap = !bus.load && bus.en && (mq == int'(bus.limit) || mq == MAX);
      if (bus.load) mq = int'(bus.din);
      else if (mwrap) mq = 0;
      else if (bus.en) mq = (mq + 1) % (MAX + 1);
      movf = mwrap ? 1'b1 : bus.ovf_clr ? 1'b0 : movf;
    end
    #1;
  endtask
  task automatic pulse_reset();
    rst = 0;
    #1;
    rst = 1;
    mq = 0; mwrap = 0; movf = 0;
  endtask
  task automatic test_reset();
    idle();
    bus.limit = 4'd15;
    #2;
    checks++;
    if (dutv !== '0) begin errors++; $display("FAIL reset_state: got %b exp %b", dutv, 7'b0); end
    #10;
    rst = 1;
    bus.en = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dutv !== expv()) begin errors++; $display("FAIL pre_reset_count: got %b exp %b", dutv, expv()); end
    #2;
    rst = 0;
    #1;
    checks++;
    if (dutv !== '0) begin errors++; $display("FAIL async_reset: got %b exp %b", dutv, 7'b0); end
    rst = 1;
    mq = 0; mwrap = 0; movf = 0;
  endtask
  task automatic test_free_run();
    bus.limit = 4'd15;
    bus.en = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus.q, bus.wrap} !== {W'(i % 16), i == 16}) begin
        errors++; $display("FAIL free_run[%0d]: got q=%0d wrap=%b exp q=%0d wrap=%b", i, bus.q, bus.wrap, i % 16, i == 16);
      end
      checks++;
      if (dutv !== expv()) begin errors++; $display("FAIL free_run_model[%0d]: got %b exp %b", i, dutv, expv()); end
    end
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL free_run_ovf: got %b exp 1", bus.ovf); end
  endtask
  task automatic test_modulo();
    idle();
    pulse_reset();
    bus.limit = 4'd9;
    bus.en = 1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if ({bus.q, bus.tc, bus.wrap} !== {W'(k % 10), k % 10 == 9, k == 10 || k == 20}) begin
        errors++; $display("FAIL modulo[%0d]: got q=%0d tc=%b wrap=%b exp q=%0d", k, bus.q, bus.tc, bus.wrap, k % 10);
      end
      checks++;
      if (dutv !== expv()) begin errors++; $display("FAIL modulo_model[%0d]: got %b exp %b", k, dutv, expv()); end
    end
  endtask
  task automatic test_priority();
    bus.clr = 1; bus.load = 1; bus.en = 1; bus.din = 4'd5;
    tick();
    checks++;
    if ({bus.q, bus.ovf} !== {4'd0, 1'b0}) begin errors++; $display("FAIL prio_clr: got q=%0d ovf=%b exp q=0 ovf=0", bus.q, bus.ovf); end
    bus.clr = 0;
    tick();
    checks++;
    if (bus.q !== 4'd5) begin errors++; $display("FAIL prio_load: got %0d exp 5", bus.q); end
    bus.load = 0;
    tick();
    checks++;
    if (bus.q !== 4'd6) begin errors++; $display("FAIL prio_en: got %0d exp 6", bus.q); end
    checks++;
    if (dutv !== expv()) begin errors++; $display("FAIL prio_model: got %b exp %b", dutv, expv()); end
  endtask
  task automatic test_load_above();
    int seq[7] = '{14, 15, 0, 1, 2, 3, 0};
    bus.limit = 4'd3; bus.load = 1; bus.din = 4'd13; bus.en = 1;
    tick();
    checks++;
    if (bus.q !== 4'd13) begin errors++; $display("FAIL load_above_load: got %0d exp 13", bus.q); end
    bus.load = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({bus.q, bus.wrap} !== {W'(seq[i]), i == 2 || i == 6}) begin
        errors++; $display("FAIL load_above[%0d]: got q=%0d wrap=%b exp q=%0d", i, bus.q, bus.wrap, seq[i]);
      end
      checks++;
      if (dutv !== expv()) begin errors++; $display("FAIL load_above_model[%0d]: got %b exp %b", i, dutv, expv()); end
    end
  endtask
  task automatic test_ovf_sticky();
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", bus.ovf); end
    bus.ovf_clr = 1;
    tick();
    checks++;
    if ({bus.q, bus.ovf} !== {4'd1, 1'b0}) begin errors++; $display("FAIL ovf_clear: got q=%0d ovf=%b exp q=1 ovf=0", bus.q, bus.ovf); end
    bus.ovf_clr = 0;
    tick();
    tick();
    checks++;
    if (bus.tc !== 1'b1) begin errors++; $display("FAIL ovf_tc: got %b exp 1", bus.tc); end
    bus.ovf_clr = 1;
    tick();
    checks++;
    if ({bus.q, bus.wrap, bus.ovf} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ovf_set_wins: got q=%0d wrap=%b ovf=%b exp q=0 wrap=1 ovf=1", bus.q, bus.wrap, bus.ovf);
    end
    bus.ovf_clr = 0;
  endtask
  task automatic test_edge_limits();
    bus.limit = 4'd0; bus.en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.q, bus.tc, bus.wrap} !== {4'd0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL limit0[%0d]: got q=%0d tc=%b wrap=%b exp q=0 tc=1 wrap=1", i, bus.q, bus.tc, bus.wrap);
      end
    end
    bus.en = 0; bus.load = 1; bus.din = 4'd7; bus.limit = 4'd15;
    tick();
    bus.load = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.q, bus.wrap} !== {4'd7, 1'b0}) begin errors++; $display("FAIL hold[%0d]: got q=%0d wrap=%b exp q=7 wrap=0", i, bus.q, bus.wrap); end
    end
    bus.limit = 4'd7;
    #1;
    checks++;
    if (bus.tc !== 1'b1) begin errors++; $display("FAIL tc_live: got %b exp 1", bus.tc); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.clr = $urandom_range(0, 99) < 4;
      bus.load = $urandom_range(0, 99) < 8;
      bus.en = $urandom_range(0, 99) < 80;
      bus.ovf_clr = $urandom_range(0, 99) < 15;
      bus.din = W'($urandom_range(0, MAX));
      if ($urandom_range(0, 99) < 10) bus.limit = W'($urandom_range(0, MAX));
      tick();
      checks++;
      if (dutv !== expv()) begin errors++; $display("FAIL random[%0d]: got %b exp %b", i, dutv, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_modulo();
    test_priority();
    test_load_above();
    test_ovf_sticky();
    test_edge_limits();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_counter.md
# up_counter

Synchronous, parameterised binary up counter, the counting-direction complement to the team's ripple down counter. The down counter resets to all-ones and decrements; this block resets to zero and increments up to a programmable limit. Its intended use is as a timebase, cycle counter and event counter in the same designs. Unlike the ripple version, every bit is clocked from a single clock, and the outputs are glitch-free between edges.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2–32.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset; asserting it low forces all state to reset values immediately.
- `en` input 1: count enable; increments `q` by one on a rising `clk` edge when high.
- `clr` input 1: synchronous clear of `q` and `ovf`.
- `load` input 1: synchronous parallel load of `din` into `q`.
- `din` input WIDTH: load value.
- `limit` input WIDTH: terminal value; `q` wraps to 0 after reaching it. It is sampled live every cycle.
- `ovf_clr` input 1: synchronous clear of the sticky `ovf` flag.
- `q` output WIDTH: current count, registered.
- `tc` output 1: terminal count, combinational from registers; `tc = (q == limit)`.
- `wrap` output 1: registered one-cycle pulse, high in the cycle immediately after a wrap-to-zero.
- `ovf` output 1: sticky registered flag; set on every wrap, held until cleared.

## Operation
- **Reset** (`rst` low, asynchronous): `q = 0`, `wrap = 0`, `ovf = 0`. `tc` then reflects `0 == limit`.
- **Per-edge priority**, highest first:
  1. `clr`: `q <= 0`, `ovf <= 0`, `wrap <= 0`.
  2. `load`: `q <= din`, `wrap <= 0`, `ovf` unchanged.
  3. `en`:
     - If `q == limit` or `q == all-ones`: `q <= 0`, `wrap <= 1`, `ovf <= 1`.
     - Otherwise: `q <= q + 1`, `wrap <= 0`.
  4. None of the above: `q` holds, `wrap <= 0`.
- **`ovf_clr`**: clears `ovf` on the edge unless a wrap occurs on the same edge. When both happen together, set wins and `ovf` stays 1.
- **Count above `limit`**: if `q > limit` (after a load or a `limit` change), counting continues upward to all-ones, then wraps to 0 with a `wrap` pulse. There is no silent rollover without `wrap`.
- **`limit = 0`**: every enabled edge produces `q = 0` with `wrap = 1` on each edge.
- **`limit = all-ones`**: the counter is a free-running modulo-2^WIDTH counter.
- **Arithmetic**: unsigned, WIDTH bits. The increment never carries outside WIDTH.
- **Independence from `en`**: `load` and `clr` act regardless of `en`.

## Timing
- **Latency**: `q`, `wrap` and `ovf` change one `clk` edge after the qualifying inputs are sampled. `tc` changes combinationally with `q` or `limit`, with no added cycle.
- **Wrap sequence**, with `en` held high: `tc` goes high in the cycle where `q == limit`. On the next edge `q = 0` and `wrap = 1`. On the edge after that, `wrap = 0` unless that edge wraps again, which only happens when `limit = 0`.
- **Count period**: with `en` continuously high and `q < limit` at start, the period is `limit + 1` cycles.
- **Reset mid-count**: `q`, `wrap` and `ovf` go to 0 without waiting for `clk`.
- **Reset release**: on release, the first rising edge with `en = 1` gives `q = 1`. Deassertion is assumed synchronised upstream.
- **Input timing**: all inputs must meet setup and hold to `clk`. `limit` may change on any cycle and takes effect at the next comparison.

## Test plan
- **Reset and free run**: `WIDTH = 4`, `limit = 15`. Pulse `rst` low mid-count → `q`, `wrap`, `ovf` all 0 asynchronously. Then `en = 1` for 20 cycles → `q` = 1..15, 0, 1..4; `wrap` high exactly once, in the cycle `q = 0`; `ovf = 1` afterwards.
- **Modulo limit**: `limit = 9`, `en = 1` for 25 cycles from reset → `q` cycles 0..9; `tc` high at each `q = 9`; `wrap` pulses at cycles 10 and 20.
- **Priority**: `clr`, `load` and `en` all high with `din = 5` → `q = 0`, `ovf = 0`. Then `load` and `en` high → `q = 5`. Then `en` alone → `q = 6`.
- **Load above limit**: `limit = 3`, load `din = 13`, `en = 1` → `q` = 14, 15, then 0 with `wrap = 1`, then 1, 2, 3, 0.
- **Sticky overflow**: force a wrap → `ovf = 1`. Assert `ovf_clr` on a non-wrap edge → `ovf = 0`. Assert `ovf_clr` on a wrap edge → `ovf` remains 1.
- **Edge limits**: `limit = 0` with `en = 1` → `q` stays 0 and `wrap` is high every cycle. `en = 0` for 10 cycles → `q` holds and `wrap = 0`.
